// File: rtl/maxpool2x2_stream_if.sv
// rtl/maxpool2x2_stream_if.sv - pixel-pair in / pooled-pair out bundle for the max-pool stage
interface maxpool2x2_stream_if #(
   parameter int DATA_W = 8,
   parameter int IDX_W  = 4
);
   logic [DATA_W-1:0] input_data_0;
   logic [DATA_W-1:0] input_data_1;
   logic              input_valid;
   logic [DATA_W-1:0] output_data_0;
   logic [DATA_W-1:0] output_data_1;
   logic              output_valid;
   logic [IDX_W-1:0]  out_index;
   logic              frame_done;

   // Upstream/downstream environment side: drives pixels, observes pooled results
   modport master (
      output input_data_0, input_data_1, input_valid,
      input  output_data_0, output_data_1, output_valid, out_index, frame_done
   );

   // Pooling stage side
   modport slave (
      input  input_data_0, input_data_1, input_valid,
      output output_data_0, output_data_1, output_valid, out_index, frame_done
   );
endinterface

// File: rtl/maxpool2x2_stream.sv
// rtl/maxpool2x2_stream.sv - streaming 2x2 stride-2 max-pool over two channels with a half-width line buffer
module maxpool2x2_stream #(
   parameter int IN_W   = 6,
   parameter int IN_H   = 6,
   parameter int DATA_W = 8
) (
   input logic                 clk,
   input logic                 reset,
   maxpool2x2_stream_if.slave  bus
);
   localparam int OW    = IN_W / 2;
   localparam int OH    = IN_H / 2;
   localparam int NOUT  = OW * OH;
   localparam int IDX_W = (NOUT > 1) ? $clog2(NOUT) : 1;
   localparam int CW    = (IN_W > 1) ? $clog2(IN_W) : 1;
   localparam int RW    = (IN_H > 1) ? $clog2(IN_H) : 1;
   localparam int LBW   = (OW > 1) ? $clog2(OW) : 1;

   logic [CW-1:0]     col;
   logic [RW-1:0]     row;
   logic [DATA_W-1:0] hold_0;
   logic [DATA_W-1:0] hold_1;
   logic [DATA_W-1:0] linebuf_0 [OW];
   logic [DATA_W-1:0] linebuf_1 [OW];

   logic [LBW-1:0]    lb_idx;
   logic [IDX_W-1:0]  pool_idx;
   logic              last_col;
   logic              last_row;
   logic [DATA_W-1:0] result_0;
   logic [DATA_W-1:0] result_1;

   function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

   // Window addressing and the full 2x2 maximum, valid on the odd-row/odd-col beat
   always_comb begin
      lb_idx   = LBW'(col >> 1);
      pool_idx = IDX_W'((32'(row) >> 1) * OW + (32'(col) >> 1));
      last_col = (col == CW'(IN_W - 1));
      last_row = (row == RW'(IN_H - 1));
      result_0 = max2(max2(linebuf_0[lb_idx], hold_0), bus.input_data_0);
      result_1 = max2(max2(linebuf_1[lb_idx], hold_1), bus.input_data_1);
   end

   // Raster counters, partial maxima and registered pooled output
   always_ff @(posedge clk) begin
      if (reset) begin
         col               <= '0;
         row               <= '0;
         hold_0            <= '0;
         hold_1            <= '0;
         for (int i = 0; i < OW; i++) begin
            linebuf_0[i] <= '0;
            linebuf_1[i] <= '0;
         end
         bus.output_data_0 <= '0;
         bus.output_data_1 <= '0;
         bus.output_valid  <= 1'b0;
         bus.out_index     <= '0;
         bus.frame_done    <= 1'b0;
      end else begin
         bus.output_valid <= 1'b0;
         bus.frame_done   <= 1'b0;
         if (bus.input_valid) begin
            if (last_col) begin
               col <= '0;
               row <= last_row ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end

            case ({row[0], col[0]})
               2'b00, 2'b10: begin
                  hold_0 <= bus.input_data_0;
                  hold_1 <= bus.input_data_1;
               end
               2'b01: begin
                  linebuf_0[lb_idx] <= max2(hold_0, bus.input_data_0);
                  linebuf_1[lb_idx] <= max2(hold_1, bus.input_data_1);
               end
               default: begin
                  bus.output_data_0 <= result_0;
                  bus.output_data_1 <= result_1;
                  bus.output_valid  <= 1'b1;
                  bus.out_index     <= pool_idx;
                  bus.frame_done    <= last_row && last_col;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_maxpool2x2_stream.sv
// tb/tb_maxpool2x2_stream.sv - scoreboard bench for the 2x2 max-pool stage
module tb_maxpool2x2_stream;
   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   maxpool2x2_stream_if #(.DATA_W(8), .IDX_W(4)) bus_if ();

   maxpool2x2_stream #(.IN_W(6), .IN_H(6), .DATA_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   typedef struct {
      logic [7:0] d0;
      logic [7:0] d1;
      logic [3:0] idx;
      logic       fd;
      int         cyc;
   } exp_t;

   exp_t sb[$];

   logic [7:0] ramp0 [9] = '{8'd7, 8'd9, 8'd11, 8'd19, 8'd21, 8'd23, 8'd31, 8'd33, 8'd35};
   logic [7:0] ramp1 [9] = '{8'd255, 8'd253, 8'd251, 8'd243, 8'd241, 8'd239, 8'd231, 8'd229, 8'd227};

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (bus_if.output_valid) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: got index %0d data %0d/%0d, required no output (cycle %0d)",
                     bus_if.out_index, bus_if.output_data_0, bus_if.output_data_1, cyc);
         end else begin
            e = sb.pop_front();
            check("out_data_0", bus_if.output_data_0, e.d0);
            check("out_data_1", bus_if.output_data_1, e.d1);
            check("out_index", bus_if.out_index, e.idx);
            check("frame_done", bus_if.frame_done, e.fd);
            check("out_latency_cycle", cyc, e.cyc);
         end
      end else if (bus_if.frame_done) begin
         check("stray_frame_done", bus_if.frame_done, 0);
      end
   end

   // kind 0: ramp, kind 1: single 200 spike at row 3 col 4, kind 2: constant 255
   task automatic drive(input int kind, input int nbeats, input bit gap);
      int p, r, c, idx;
      logic [7:0] a, b;
      exp_t e;
      for (int k = 0; k < nbeats; k++) begin
         p = k % 36;
         r = p / 6;
         c = p % 6;
         case (kind)
            0: begin a = 8'(p); b = 8'(255 - p); end
            1: begin a = (r == 3 && c == 4) ? 8'd200 : 8'd0; b = 8'd0; end
            default: begin a = 8'd255; b = 8'd255; end
         endcase
         bus_if.input_data_0 = a;
         bus_if.input_data_1 = b;
         bus_if.input_valid  = 1'b1;
         if ((r % 2 == 1) && (c % 2 == 1)) begin
            idx = (r / 2) * 3 + c / 2;
            case (kind)
               0: begin e.d0 = ramp0[idx]; e.d1 = ramp1[idx]; end
               1: begin e.d0 = (idx == 5) ? 8'd200 : 8'd0; e.d1 = 8'd0; end
               default: begin e.d0 = 8'd255; e.d1 = 8'd255; end
            endcase
            e.idx = 4'(idx);
            e.fd  = (idx == 8);
            e.cyc = cyc + 1;
            sb.push_back(e);
         end
         @(posedge clk); #1;
         if (gap) begin
            bus_if.input_valid  = 1'b0;
            bus_if.input_data_0 = 8'hA5;
            bus_if.input_data_1 = 8'h5A;
            @(posedge clk); #1;
         end
      end
      bus_if.input_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      bus_if.input_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset               = 1'b1;
      bus_if.input_data_0 = '0;
      bus_if.input_data_1 = '0;
      bus_if.input_valid  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_output_valid", bus_if.output_valid, 0);
      check("reset_output_data_0", bus_if.output_data_0, 0);
      check("reset_output_data_1", bus_if.output_data_1, 0);
      check("reset_out_index", bus_if.out_index, 0);
      check("reset_frame_done", bus_if.frame_done, 0);
      reset = 1'b0;

      drive(0, 36, 1'b0);
      idle(3);
      drive(0, 36, 1'b1);
      idle(3);
      drive(1, 36, 1'b0);
      idle(3);

      drive(0, 20, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("midframe_reset_out_index", bus_if.out_index, 0);
      check("midframe_reset_output_valid", bus_if.output_valid, 0);
      check("midframe_reset_output_data_0", bus_if.output_data_0, 0);
      drive(2, 36, 1'b0);
      idle(3);

      drive(0, 72, 1'b0);
      drive(2, 36, 1'b0);
      idle(4);

      check("scoreboard_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
